// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch conditioning and display/scan logic.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   CLK_HZ_DEFAULT       default core clock frequency in Hz
//   MS_TICK_HZ           rate of the shared millisecond strobe
//   DEBOUNCE_MS_DEFAULT  default debounce window in milliseconds
//   dbnc_cnt_t           per-bit debounce window counter type
//   tick_div()           clock cycles per millisecond tick
package board_pkg;

  localparam int CLK_HZ_DEFAULT      = 50_000_000;
  localparam int MS_TICK_HZ          = 1000;
  localparam int DEBOUNCE_MS_DEFAULT = 10;

  // Window counter only has to reach DEBOUNCE_MS-1, and DEBOUNCE_MS tops out at 255.
  localparam int DEBOUNCE_CNT_W = 8;
  typedef logic [DEBOUNCE_CNT_W-1:0] dbnc_cnt_t;

  // Number of core clock cycles in one millisecond tick period.
  function automatic int tick_div(input int clk_hz);
    return clk_hz / MS_TICK_HZ;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit switch conditioner: 2-flop synchronizer, tick-paced debounce window, edge pulses.
// Latency: 2 cycles sync + (DEBOUNCE_MS-1)*TICK_DIV+1 .. DEBOUNCE_MS*TICK_DIV cycles to accept.
// Backpressure: none; free-running, outputs are levels and one-cycle pulses.
//
// Ports:
//   CLOCK_50  clock, rising edge
//   reset     synchronous active-high reset
//   tick      shared 1 kHz strobe, one cycle wide
//   sw_raw    asynchronous switch bit
//   sw_clean  debounced level
//   sw_rise   one-cycle pulse, coincident with sw_clean going 0->1
//   sw_fall   one-cycle pulse, coincident with sw_clean going 1->0
module debounce_bit
  import board_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam dbnc_cnt_t CNT_LAST = dbnc_cnt_t'(DEBOUNCE_MS - 1);

  logic      s1;
  logic      s2;
  logic      stable;
  dbnc_cnt_t cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      s1      <= sw_raw;
      s2      <= s1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      if (s2 == stable) begin
        // Any agreement, even for one cycle, restarts the window.
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          // Pulses are registered alongside stable so they line up with sw_clean.
          stable  <= s2;
          cnt     <= '0;
          sw_rise <= s2;
          sw_fall <= ~s2;
        end else begin
          cnt <= cnt + dbnc_cnt_t'(1);
        end
      end
    end
  end

  assign sw_clean = stable;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches against a shared millisecond tick and reports clean edges.
// Latency: 2 cycles sync + (DEBOUNCE_MS-1)*TICK_DIV+1 .. DEBOUNCE_MS*TICK_DIV cycles to accept.
// Backpressure: none; free-running, every output is a flop.
//
// Ports:
//   CLOCK_50  clock, rising edge
//   reset     synchronous active-high reset
//   sw_raw    asynchronous switch inputs
//   sw_clean  debounced levels
//   sw_rise   one-cycle pulses on clean 0->1 transitions
//   sw_fall   one-cycle pulses on clean 1->0 transitions
//   tick      1 kHz one-cycle strobe, shared with display/scan logic
module switch_debouncer
  import board_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);

  localparam int TICK_DIV = tick_div(CLK_HZ);
  localparam int PRE_W    = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  // tick is registered, so it is armed one count early to be high while pre == PRE_LAST.
  localparam logic [PRE_W-1:0] PRE_ARM  = PRE_W'(TICK_DIV - 2);

  logic [PRE_W-1:0] pre;
  logic             tick_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      pre    <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      tick_q <= (pre == PRE_ARM);
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce_bit (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick_q),
      .sw_raw   (sw_raw[g]),
      .sw_clean (sw_clean[g]),
      .sw_rise  (sw_rise[g]),
      .sw_fall  (sw_fall[g])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with an event-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_switch_debouncer;

  localparam int W  = 10;
  localparam int TD = 8;
  localparam int DM = 4;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         tick;

  switch_debouncer #(
    .WIDTH       (W),
    .CLK_HZ      (8000),
    .DEBOUNCE_MS (DM)
  ) u_dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .tick     (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: s2 is the raw input two edges late, ticks fall on every TD-th
  // edge since reset, and a bit accepts once its disagreement has lasted DM ticks.
  int           m_n;
  int           m_run [W];
  logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  logic         m_tick;

  task automatic model_step();
    logic tick_pre;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
      m_n = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      tick_pre = ((m_n % TD) == TD - 1);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else if (tick_pre) begin
          m_run[i]++;
          if (m_run[i] == DM) begin
            m_stable[i] = m_s2[i];
            m_run[i]    = 0;
            if (m_s2[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
      m_n++;
    end
    m_tick = ((m_n % TD) == TD - 1);
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_step();
    #1;
    chk("clean", 32'(sw_clean), 32'(m_stable));
    chk("rise",  32'(sw_rise),  32'(m_rise));
    chk("fall",  32'(sw_fall),  32'(m_fall));
    chk("tick",  32'(tick),     32'(m_tick));
    chk("rise_fall_excl", 32'(sw_rise & sw_fall), 32'd0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_bit(input int idx, input logic val, input int max_c, output int lat);
    lat = -1;
    for (int k = 1; k <= max_c; k++) begin
      cycle();
      if (sw_clean[idx] == val) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int reached;
    int lat;
    int early;
    int bad;
    logic seen;

    // Reset with all switches up; everything reads zero while reset is held.
    reset  = 1'b1;
    sw_raw = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_clean", 32'(sw_clean), 32'd0);
      chk("rst_rise",  32'(sw_rise),  32'd0);
      chk("rst_fall",  32'(sw_fall),  32'd0);
      chk("rst_tick",  32'(tick),     32'd0);
    end
    reset   = 1'b0;
    hits    = 0;
    reached = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (sw_rise == 10'h3FF) hits++;
      if (reached == 0 && sw_clean == 10'h3FF) reached = k;
    end
    chk("rst_accept_within_34", 32'(reached >= 1 && reached <= 34), 32'd1);
    chk("rst_rise_once", 32'(hits), 32'd1);

    // All switches down together.
    sw_raw = '0;
    hits   = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (sw_fall == 10'h3FF) hits++;
    end
    chk("all_fall_once", 32'(hits), 32'd1);

    // Clean flip on bit 0.
    sw_raw = 10'h001;
    wait_bit(0, 1'b1, 40, lat);
    chk("flip_lat_25_34", 32'(lat >= 25 && lat <= 34), 32'd1);
    chk("flip_rise_same_cycle", 32'(sw_rise), 32'h001);
    run(5);
    sw_raw = '0;
    hits   = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (sw_fall[0]) hits++;
    end
    chk("flip_fall_once", 32'(hits), 32'd1);

    // Bounce rejection on bit 3.
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (k % 5 == 0) sw_raw[3] = ~sw_raw[3];
      cycle();
      if (sw_clean[3] || sw_rise[3] || sw_fall[3]) bad++;
    end
    sw_raw[3] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (sw_clean[3] || sw_rise[3] || sw_fall[3]) bad++;
    end
    chk("bounce_quiet", 32'(bad), 32'd0);

    // Restart on bounce: a 2-cycle dropout resets the window on bit 1.
    early = 0;
    sw_raw[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (sw_clean[1]) early++;
    end
    sw_raw[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      if (sw_clean[1]) early++;
    end
    sw_raw[1] = 1'b1;
    wait_bit(1, 1'b1, 40, lat);
    chk("restart_no_early", 32'(early), 32'd0);
    chk("restart_lat_25_34", 32'(lat >= 25 && lat <= 34), 32'd1);

    // Simultaneous acceptance of five bits.
    sw_raw = '0;
    run(40);
    sw_raw = 10'h155;
    hits   = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (sw_rise == 10'h155) hits++;
      if (!seen && sw_clean != '0) begin
        seen = 1'b1;
        chk("simul_clean_together", 32'(sw_clean), 32'h155);
        chk("simul_rise_together",  32'(sw_rise),  32'h155);
      end
    end
    chk("simul_seen", 32'(seen), 32'd1);
    chk("simul_rise_once", 32'(hits), 32'd1);

    // Mid-operation reset at window count 2 on bit 2.
    sw_raw = '0;
    run(40);
    sw_raw = 10'h004;
    seen   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (m_run[2] == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_reached_cnt2", 32'(seen), 32'd1);
    reset = 1'b1;
    cycle();
    chk("midrst_clean", 32'(sw_clean), 32'd0);
    chk("midrst_tick",  32'(tick),     32'd0);
    reset = 1'b0;
    wait_bit(2, 1'b1, 40, lat);
    chk("midrst_full_window", 32'(lat), 32'd32);

    // Randomized traffic against the model.
    for (int s = 0; s < 80; s++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end else begin
        if (r < 10) sw_raw = W'($urandom);
        else        sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
        run($urandom_range(1, 45));
      end
    end
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions raw slide-switch inputs before they reach the board's registered logic (the 5-bit enable/reset data register driven from SW). Each bit passes through a two-flop synchronizer and a millisecond-tick debounce filter. The block presents clean levels plus one-cycle rise/fall pulses, so downstream stages see one glitch-free transition per physical flip.

## Interface
Parameters:
- `WIDTH`, 10, number of switch bits conditioned.
- `CLK_HZ`, 50_000_000, clock frequency in Hz; must be a multiple of 1000 and ≥ 2000.
- `DEBOUNCE_MS`, 10, ticks of continuous disagreement required to accept a new level; range 1..255.

Ports:
- `CLOCK_50` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sw_raw` in WIDTH: asynchronous switch inputs.
- `sw_clean` out WIDTH: debounced level per bit.
- `sw_rise` out WIDTH: one-cycle pulse when `sw_clean[i]` goes 0→1.
- `sw_fall` out WIDTH: one-cycle pulse when `sw_clean[i]` goes 1→0.
- `tick` out 1: 1 kHz strobe, one cycle wide; exported for reuse by display/scan logic.

## Operation
- Synchronizer: per bit, `s1 <= sw_raw`, `s2 <= s1`. Only `s2` is used downstream.
- Prescaler: counter `pre` counts 0..TICK_DIV-1, where TICK_DIV = CLK_HZ/1000.
  - `tick` = 1 in the cycle `pre == TICK_DIV-1`; `pre` then wraps to 0.
  - Width is `$clog2(TICK_DIV)`.
- Per-bit filter:
  - State: `stable` (drives `sw_clean`) and 8-bit `cnt`.
  - If `s2 == stable`: `cnt <= 0`, every cycle regardless of tick. A bounce back restarts the window.
  - If `s2 != stable` and `tick`:
    - If `cnt == DEBOUNCE_MS-1`: `stable <= s2`, `cnt <= 0`, and pulse the matching edge output.
    - Otherwise `cnt <= cnt+1`.
  - If `s2 != stable` and no tick: hold.
- Pulses are registered and asserted in the same cycle `sw_clean` shows its new value. `sw_rise[i]` and `sw_fall[i]` are never both 1. Pulses deassert the following cycle.
- Bits are fully independent. Any number of bits may change in the same cycle.
- Reset (synchronous, highest priority, honoured mid-count):
  - Synchronizer flops, `pre`, every `cnt`, `stable`, `sw_clean`, `sw_rise`, `sw_fall`, and `tick` are all 0 after the first clock edge with `reset` high.
  - A switch held at 1 through reset release is re-accepted after a full debounce window and produces exactly one `sw_rise`.

## Timing
- Synchronizer latency: 2 cycles from a `sw_raw` change to `s2`.
- Acceptance:
  - After `s2` changes, `stable` updates on the DEBOUNCE_MS-th subsequent tick, provided `s2` stays constant throughout.
  - Latency from `s2` change is between (DEBOUNCE_MS-1)·TICK_DIV+1 and DEBOUNCE_MS·TICK_DIV cycles, depending on tick phase.
- Rejection: a pulse on `s2` shorter than (DEBOUNCE_MS-1)·TICK_DIV+1 cycles is never accepted.
- Combinational paths: none from input to output. All outputs are flop-driven.
- Wrap-around: `cnt` never exceeds DEBOUNCE_MS-1. `pre` wraps exactly at TICK_DIV-1.

## Structure
- Shared package `board_pkg`:
  - `CLK_HZ_DEFAULT` = 50_000_000.
  - `MS_TICK_HZ` = 1000.
  - `DEBOUNCE_MS_DEFAULT` = 10.
  - Display/scan blocks reuse the same constants.
- Sub-module `debounce_bit`: one synchronizer + `cnt` + `stable` + edge pulses, with inputs `CLOCK_50`, `reset`, `tick`, and raw bit. Instantiated WIDTH times in a generate loop.
- The prescaler lives once in the top of this block.

## Test plan
All scenarios use `CLK_HZ=8000` (TICK_DIV=8), `DEBOUNCE_MS=4`, `WIDTH=10`.
- **Reset values:** hold `reset` 3 cycles with `sw_raw=10'h3FF` → all outputs 0 during reset. After release, `sw_clean` reaches 10'h3FF within 34 cycles, and `sw_rise` = 10'h3FF for exactly one cycle.
- **Clean flip:** `sw_raw[0]` 0→1 held → `sw_clean[0]`=1 within 25..34 cycles of the change, with a single `sw_rise[0]` in that same cycle. A later 1→0 gives a single `sw_fall[0]`.
- **Bounce rejection:** toggle `sw_raw[3]` every 5 cycles for 200 cycles, then leave it at 0 → `sw_clean[3]` stays 0, and no pulse appears on bit 3.
- **Restart on bounce:** `sw_raw[1]`=1 for 20 cycles, 0 for 2 cycles, then 1 held → acceptance latency is measured from the final rise; no early acceptance.
- **Simultaneous bits:** `sw_raw` 10'h000→10'h155 in one cycle → all five bits accept on the same cycle, with `sw_rise`=10'h155 for one cycle.
- **Mid-operation reset:** assert `reset` for 1 cycle at count 2 of a pending flip → `cnt` is cleared. With `sw_raw` still changed, acceptance occurs a full window after reset release.
